sensor_array_interface: RTL and testbench

Parametrised multi-channel front end for the parking system's vehicle sensors: synchronises, debounces and tracks up to `NUM_CH` raw sensor lines (entry/exit lanes, bay sensors). Emits one-cycle `passed` pulses, a sticky per-channel stuck-sensor fault and a saturating aggregate passage count. Sits between the pad-level sensor inputs and the gate/occupancy controller.

---
 rtl/sensor_pkg.sv | 14 +
 rtl/sensor_channel.sv | 116 +++++++++++
 rtl/sensor_array_interface.sv | 89 ++++++++
 tb/tb_sensor_array_interface.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared state encoding for the parking sensor front end
//
// Purpose : Channel FSM state enumeration, shared by sensor_channel and
//           other parking blocks that decode per-channel occupancy state.
// Ports   : none (package)
package sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OCCUPIED = 2'd1,
        ST_STUCK    = 2'd2
    } sensor_state_t;

endpackage

// File: rtl/sensor_channel.sv
// rtl/sensor_channel.sv - one sensor line: synchroniser, debounce, passage FSM, occupancy timer
//
// Purpose : Cleans up one raw sensor line and tracks a vehicle passing it.
// Ports   : i_clk, i_reset      clock, asynchronous active-high reset
//           i_raw               asynchronous raw line (1 = beam blocked)
//           i_enable            channel takes part in passage/fault tracking
//           i_fault_clear       request to leave the stuck state
//           o_stable            debounced level
//           o_passed            one-cycle pulse when a vehicle has fully passed
//           o_stuck             channel is in the stuck state
module sensor_channel
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_DELAY = 5,
    parameter int STUCK_TIMEOUT  = 1000,
    parameter int TIMER_W        = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    input  logic i_enable,
    input  logic i_fault_clear,
    output logic o_stable,
    output logic o_passed,
    output logic o_stuck
);

    localparam int DB_W = (DEBOUNCE_DELAY > 1) ? $clog2(DEBOUNCE_DELAY) : 1;
    localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_DELAY - 1);
    localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(STUCK_TIMEOUT - 1);

    logic [1:0]         r_sync;
    logic [DB_W-1:0]    r_db_cnt;
    logic               r_stable;
    sensor_state_t      r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_passed;

    sensor_state_t      w_state_nxt;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               w_passed_nxt;

    // Debounce: the stable level only flips after DEBOUNCE_DELAY consecutive
    // synchronised samples disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync   <= 2'b00;
            r_db_cnt <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] != r_stable) begin
                if (r_db_cnt == DB_LAST) begin
                    r_stable <= ~r_stable;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_passed <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_passed <= w_passed_nxt;
        end
    end

    // Within OCCUPIED, losing the enable discards the occupancy, and a falling
    // stable level takes priority over the timeout so a late release still counts.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = '0;
        w_passed_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_stable && i_enable) begin
                    w_state_nxt = ST_OCCUPIED;
                end
            end
            ST_OCCUPIED: begin
                if (!i_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (!r_stable) begin
                    w_state_nxt  = ST_IDLE;
                    w_passed_nxt = 1'b1;
                end else if (r_timer == TO_LAST) begin
                    w_state_nxt = ST_STUCK;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_STUCK: begin
                if (i_fault_clear && !r_stable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_stable = r_stable;
    assign o_passed = r_passed;
    assign o_stuck  = (r_state == ST_STUCK);

endmodule

// File: rtl/sensor_array_interface.sv
// rtl/sensor_array_interface.sv - multi-channel parking sensor front end
//
// Purpose : NUM_CH debounced sensor channels plus aggregate fault flag and
//           saturating passage counter.
// Ports   : i_clk, i_reset         clock, asynchronous active-high reset
//           i_raw_sensor           raw sensor lines
//           i_channel_enable       per-channel tracking enable
//           i_fault_clear          per-channel stuck-fault clear
//           o_sensor_stable        debounced levels
//           o_passed               per-channel passage pulses
//           o_stuck_fault          per-channel sticky stuck flags
//           o_any_fault            registered OR of o_stuck_fault
//           o_total_count          saturating count of passage pulses
module sensor_array_interface
    import sensor_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_DELAY = 5,
    parameter int STUCK_TIMEOUT  = 1000,
    parameter int TIMER_W        = 16,
    parameter int CNT_W          = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NUM_CH-1:0] i_raw_sensor,
    input  logic [NUM_CH-1:0] i_channel_enable,
    input  logic [NUM_CH-1:0] i_fault_clear,
    output logic [NUM_CH-1:0] o_sensor_stable,
    output logic [NUM_CH-1:0] o_passed,
    output logic [NUM_CH-1:0] o_stuck_fault,
    output logic              o_any_fault,
    output logic [CNT_W-1:0]  o_total_count
);

    localparam int PC_W  = $clog2(NUM_CH + 1);
    localparam int SUM_W = CNT_W + PC_W;

    logic [NUM_CH-1:0] w_passed;
    logic [NUM_CH-1:0] w_stuck;
    logic [PC_W-1:0]   w_pop;
    logic [SUM_W-1:0]  w_sum;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [CNT_W-1:0]  r_count;
    logic              r_any_fault;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sensor_channel #(
            .DEBOUNCE_DELAY (DEBOUNCE_DELAY),
            .STUCK_TIMEOUT  (STUCK_TIMEOUT),
            .TIMER_W        (TIMER_W)
        ) u_ch (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_raw         (i_raw_sensor[g]),
            .i_enable      (i_channel_enable[g]),
            .i_fault_clear (i_fault_clear[g]),
            .o_stable      (o_sensor_stable[g]),
            .o_passed      (w_passed[g]),
            .o_stuck       (w_stuck[g])
        );
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop = w_pop + PC_W'(w_passed[i]);
        end
    end

    // Widened sum: any carry above CNT_W means the counter would wrap, so clamp.
    assign w_sum       = SUM_W'(r_count) + SUM_W'(w_pop);
    assign w_count_nxt = (w_sum[SUM_W-1:CNT_W] != '0) ? '1 : w_sum[CNT_W-1:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count     <= '0;
            r_any_fault <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_any_fault <= |w_stuck;
        end
    end

    assign o_passed      = w_passed;
    assign o_stuck_fault = w_stuck;
    assign o_any_fault   = r_any_fault;
    assign o_total_count = r_count;

endmodule

// File: tb/tb_sensor_array_interface.sv
// tb/tb_sensor_array_interface.sv - self-checking bench for sensor_array_interface
module tb_sensor_array_interface;

    localparam int NCH = 4;
    localparam int DD  = 5;
    localparam int TO  = 20;
    localparam int CW  = 4;
    localparam int TW  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NCH-1:0]  raw, en, fc;
    logic [NCH-1:0]  o_stable, o_passed, o_stuck;
    logic            o_any;
    logic [CW-1:0]   o_count;
    logic [16:0]     dv;

    always #5 clk = ~clk;

    sensor_array_interface #(
        .NUM_CH(NCH), .DEBOUNCE_DELAY(DD), .STUCK_TIMEOUT(TO), .TIMER_W(TW), .CNT_W(CW)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_raw_sensor     (raw),
        .i_channel_enable (en),
        .i_fault_clear    (fc),
        .o_sensor_stable  (o_stable),
        .o_passed         (o_passed),
        .o_stuck_fault    (o_stuck),
        .o_any_fault      (o_any),
        .o_total_count    (o_count)
    );

    assign dv = {o_stable, o_passed, o_stuck, o_any, o_count};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is described by how long its synchronised
    // sample has disagreed with the filtered level, and by how many edges it
    // has been occupied (-1 = not occupied), plus a separate stuck flag.
    logic [NCH-1:0] m_s1, m_s2, m_stable, m_passed, m_stuck;
    int             m_run [NCH];
    int             m_age [NCH];
    logic           m_any;
    int             m_count;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_passed = '0; m_stuck = '0;
        m_any = 1'b0; m_count = 0;
        for (int c = 0; c < NCH; c++) begin
            m_run[c] = 0;
            m_age[c] = -1;
        end
    endtask

    task automatic model_edge();
        logic [NCH-1:0] np, ns;
        int total;
        total   = m_count + $countones(m_passed);
        m_count = (total > (1 << CW) - 1) ? (1 << CW) - 1 : total;
        m_any   = |m_stuck;
        np = '0;
        ns = m_stuck;
        for (int c = 0; c < NCH; c++) begin
            if (m_stuck[c]) begin
                if (fc[c] && !m_stable[c]) ns[c] = 1'b0;
            end else if (m_age[c] < 0) begin
                if (m_stable[c] && en[c]) m_age[c] = 0;
            end else if (!en[c]) begin
                m_age[c] = -1;
            end else if (!m_stable[c]) begin
                m_age[c] = -1;
                np[c] = 1'b1;
            end else if (m_age[c] + 1 == TO) begin
                m_age[c] = -1;
                ns[c] = 1'b1;
            end else begin
                m_age[c] = m_age[c] + 1;
            end
            if (m_s2[c] != m_stable[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == DD) begin
                    m_stable[c] = ~m_stable[c];
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
        m_passed = np;
        m_stuck = ns;
    endtask

    function automatic logic [16:0] model_vec();
        logic [CW-1:0] cnt;
        cnt = m_count[CW-1:0];
        return {m_stable, m_passed, m_stuck, m_any, cnt};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            if (!reset) model_edge();
            #1;
            check("model", dv, model_vec());
        end
    endtask

    typedef struct {
        logic [3:0] raw, en, fc;
        int         n;
        logic [3:0] e_stable, e_passed, e_stuck;
        logic       e_any;
        logic [3:0] e_count;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] e, input logic [3:0] f,
                                input int n, input logic [3:0] es, input logic [3:0] ep,
                                input logic [3:0] ek, input logic ea, input logic [3:0] ec);
        vec_t v;
        v.raw = r; v.en = e; v.fc = f; v.n = n;
        v.e_stable = es; v.e_passed = ep; v.e_stuck = ek; v.e_any = ea; v.e_count = ec;
        return v;
    endfunction

    vec_t tbl [$];
    logic [3:0] seen;

    initial begin
        reset = 1'b1; raw = '0; en = '0; fc = '0;
        model_reset();
        tbl = {};
        // ch0 glitch shorter than the debounce window
        tbl.push_back(mk(4'h1, 4'hF, 4'h0,  3, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h0, 4'hF, 4'h0, 10, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0));
        // ch1 normal passage: rise on 7th edge, fall on 7th low edge, pulse, count
        tbl.push_back(mk(4'h2, 4'hF, 4'h0,  6, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h2, 4'hF, 4'h0,  1, 4'h2, 4'h0, 4'h0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h2, 4'hF, 4'h0,  3, 4'h2, 4'h0, 4'h0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h0, 4'hF, 4'h0,  6, 4'h2, 4'h0, 4'h0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h0, 4'hF, 4'h0,  1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h0, 4'hF, 4'h0,  1, 4'h0, 4'h2, 4'h0, 1'b0, 4'h0));
        tbl.push_back(mk(4'h0, 4'hF, 4'h0,  1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1));
        // ch2 stuck: occupied from 8th edge, stuck 20 edges later, any_fault one after
        tbl.push_back(mk(4'h4, 4'hF, 4'h0,  6, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1));
        tbl.push_back(mk(4'h4, 4'hF, 4'h0,  1, 4'h4, 4'h0, 4'h0, 1'b0, 4'h1));
        tbl.push_back(mk(4'h4, 4'hF, 4'h0, 20, 4'h4, 4'h0, 4'h0, 1'b0, 4'h1));
        tbl.push_back(mk(4'h4, 4'hF, 4'h0,  1, 4'h4, 4'h0, 4'h4, 1'b0, 4'h1));
        tbl.push_back(mk(4'h4, 4'hF, 4'h0,  1, 4'h4, 4'h0, 4'h4, 1'b1, 4'h1));
        tbl.push_back(mk(4'h4, 4'hF, 4'h4,  3, 4'h4, 4'h0, 4'h4, 1'b1, 4'h1));
        tbl.push_back(mk(4'h0, 4'hF, 4'h0,  6, 4'h4, 4'h0, 4'h4, 1'b1, 4'h1));
        tbl.push_back(mk(4'h0, 4'hF, 4'h0,  1, 4'h0, 4'h0, 4'h4, 1'b1, 4'h1));
        tbl.push_back(mk(4'h0, 4'hF, 4'h4,  1, 4'h0, 4'h0, 4'h0, 1'b1, 4'h1));
        tbl.push_back(mk(4'h0, 4'hF, 4'h0,  1, 4'h0, 4'h0, 4'h0, 1'b0, 4'h1));

        tick(3);
        check("reset_state", dv, 17'h0);
        #2;
        reset = 1'b0;
        en = 4'hF;
        tick(2);

        for (int i = 0; i < tbl.size(); i++) begin
            raw = tbl[i].raw; en = tbl[i].en; fc = tbl[i].fc;
            tick(tbl[i].n);
            check($sformatf("vec%0d", i), dv,
                  {tbl[i].e_stable, tbl[i].e_passed, tbl[i].e_stuck, tbl[i].e_any, tbl[i].e_count});
        end
        fc = '0;

        // ch3 disabled: stable follows the line but no passage is reported
        en = 4'h7; raw = 4'h8; seen = '0;
        tick(6);
        check("dis_stable_lo", 32'(o_stable[3]), 32'h0);
        tick(1);
        check("dis_stable_hi", 32'(o_stable[3]), 32'h1);
        for (int k = 0; k < 3; k++) begin tick(1); seen |= o_passed; end
        raw = 4'h0;
        for (int k = 0; k < 15; k++) begin tick(1); seen |= o_passed; end
        check("dis_no_passed", 32'(seen), 32'h0);
        check("dis_count", 32'(o_count), 32'h1);

        // reset in the middle of a ch1 occupancy
        en = 4'hF; raw = 4'h2;
        tick(12);
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_async", dv, 17'h0);
        raw = 4'h0;
        tick(2);
        reset = 1'b0;
        seen = '0;
        for (int k = 0; k < 20; k++) begin tick(1); seen |= o_passed; end
        check("rst_no_passed", 32'(seen), 32'h0);
        check("rst_count", 32'(o_count), 32'h0);

        // four simultaneous passages, four times: 16 clamps at 15
        for (int k = 1; k <= 4; k++) begin
            raw = 4'hF;
            tick(10);
            raw = 4'h0;
            tick(7);
            tick(1);
            check($sformatf("sat_pulse%0d", k), 32'(o_passed), 32'hF);
            tick(1);
            check($sformatf("sat_count%0d", k), 32'(o_count), (4 * k > 15) ? 32'd15 : 32'(4 * k));
            tick(3);
        end
        tick(5);
        check("sat_hold", 32'(o_count), 32'd15);

        // randomized traffic against the reference model
        reset = 1'b1;
        model_reset();
        tick(1);
        reset = 1'b0;
        raw = '0; en = 4'hF; fc = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 24) == 0) raw[c] = ~raw[c];
                if ($urandom_range(0, 149) == 0) en[c] = ~en[c];
                fc[c] = ($urandom_range(0, 7) == 0);
            end
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
